// File: rtl/alien_swarm_ctrl_if.sv
// ---------------------------------------------------------------------------
// alien_swarm_ctrl_if
// Groups the shot-interaction signals of the alien swarm controller.
//   hit_valid/hit_x/hit_y : player shot position to test against the swarm
//   hit_ack/hit_row/hit_col : pulse plus cell coordinates when a shot kills
//   fire_req/fire_valid/fire_x/fire_y : alien shot request and spawn point
// Modports:
//   master : the game side (player-shot block / alien-shot block)
//   slave  : the swarm controller
// ---------------------------------------------------------------------------
interface alien_swarm_ctrl_if #(
  parameter int NUM_ROWS    = 4,
  parameter int NUM_COLUMNS = 8
);
  localparam int ROW_W = (NUM_ROWS    > 1) ? $clog2(NUM_ROWS)    : 1;
  localparam int COL_W = (NUM_COLUMNS > 1) ? $clog2(NUM_COLUMNS) : 1;

  logic              hit_valid;
  logic [15:0]       hit_x;
  logic [15:0]       hit_y;
  logic              hit_ack;
  logic [ROW_W-1:0]  hit_row;
  logic [COL_W-1:0]  hit_col;

  logic              fire_req;
  logic              fire_valid;
  logic [15:0]       fire_x;
  logic [15:0]       fire_y;

  modport master (
    output hit_valid, hit_x, hit_y, fire_req,
    input  hit_ack, hit_row, hit_col, fire_valid, fire_x, fire_y
  );

  modport slave (
    input  hit_valid, hit_x, hit_y, fire_req,
    output hit_ack, hit_row, hit_col, fire_valid, fire_x, fire_y
  );
endinterface

// File: rtl/alien_swarm_ctrl.sv
// ---------------------------------------------------------------------------
// alien_swarm_ctrl
// Owns the NUM_ROWS x NUM_COLUMNS alive map of the alien formation, marches
// it left/right with a step-down at each screen edge, speeds up as aliens
// die, resolves player-shot hits and renders the registered alien pixel.
//
// Ports:
//   clk, rst          : single clock, synchronous active-high reset
//   frame_tick_i      : one-cycle pulse per video frame
//   restart_i         : reload the formation and bump the level
//   scan_x_i/scan_y_i : current VGA scan position
//   bus (slave)       : hit request/ack and alien fire request/spawn point
//   alive_matrix_o    : alive map, bit [row*NUM_COLUMNS + col]
//   alive_count_o     : number of live aliens
//   formation_x_o/y_o : pixel origin of cell[0][0]
//   level_o, state_o  : current level and encoded FSM state
//   cleared_o, invaded_o : terminal-state flags
//   alien_pixel_o     : registered "scan is over a live alien" pixel
//
// Build option: define ALIEN_FIRE_EN to enable alien firing. Without it the
// fire outputs are tied to zero and fire_req is ignored.
// ---------------------------------------------------------------------------
module alien_swarm_ctrl #(
  parameter int NUM_ROWS         = 4,
  parameter int NUM_COLUMNS      = 8,
  parameter int SPACING_X        = 64,
  parameter int SPACING_Y        = 32,
  parameter int ALIEN_W          = 32,
  parameter int ALIEN_H          = 16,
  parameter int INIT_X           = 100,
  parameter int INIT_Y           = 50,
  parameter int SCREEN_W         = 640,
  parameter int INVADE_Y         = 440,
  parameter int STEP_X           = 4,
  parameter int STEP_Y           = 16,
  parameter int MIN_PERIOD       = 2,
  parameter int PERIOD_PER_ALIEN = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick_i,
  input  logic        restart_i,
  input  logic [15:0] scan_x_i,
  input  logic [15:0] scan_y_i,
  alien_swarm_ctrl_if.slave bus,
  output logic [NUM_ROWS*NUM_COLUMNS-1:0] alive_matrix_o,
  output logic [15:0] alive_count_o,
  output logic [15:0] formation_x_o,
  output logic [15:0] formation_y_o,
  output logic [3:0]  level_o,
  output logic [2:0]  state_o,
  output logic        cleared_o,
  output logic        invaded_o,
  output logic        alien_pixel_o
);

  localparam int CELLS = NUM_ROWS * NUM_COLUMNS;
  localparam int ROW_W = (NUM_ROWS    > 1) ? $clog2(NUM_ROWS)    : 1;
  localparam int COL_W = (NUM_COLUMNS > 1) ? $clog2(NUM_COLUMNS) : 1;
  localparam int IDX_W = (CELLS       > 1) ? $clog2(CELLS)       : 1;

  typedef enum logic [2:0] {
    ST_MARCH_R = 3'd0,
    ST_DESC_R  = 3'd1,
    ST_MARCH_L = 3'd2,
    ST_DESC_L  = 3'd3,
    ST_CLEARED = 3'd4,
    ST_INVADED = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [CELLS-1:0]   alive_q, alive_d;
  logic [15:0]        fx_q, fx_d;
  logic [15:0]        fy_q, fy_d;
  logic [15:0]        tick_q, tick_d;
  logic [3:0]         level_q, level_d;
  logic               hit_ack_q, hit_ack_d;
  logic [ROW_W-1:0]   hit_row_q, hit_row_d;
  logic [COL_W-1:0]   hit_col_q, hit_col_d;
  logic               pixel_q, pixel_d;

  logic [15:0]            aliveCnt;
  logic [NUM_COLUMNS-1:0] colLive;
  logic [NUM_ROWS-1:0]    rowLive;
  logic [COL_W-1:0]       lcol, rcol;
  logic [ROW_W-1:0]       lrow;
  logic [15:0]            rightEdge, leftEdge;
  logic [31:0]            periodBase, period;
  logic                   terminal;
  logic                   hitKill;
  logic [IDX_W-1:0]       hitIdx;
  logic [ROW_W-1:0]       hitRowSel;
  logic [COL_W-1:0]       hitColSel;
  logic                   pixelHit;
  logic                   stepFire;

  // Point-in-sprite test; the upper bound is computed in 17 bits so a box
  // near the top of the 16-bit range cannot wrap and swallow small coords.
  function automatic logic inBox(input logic [15:0] px, input logic [15:0] py,
                                 input logic [15:0] bx, input logic [15:0] by);
    logic [16:0] xEnd, yEnd;
    xEnd = {1'b0, bx} + 17'(ALIEN_W);
    yEnd = {1'b0, by} + 17'(ALIEN_H);
    return (px >= bx) && ({1'b0, px} < xEnd) && (py >= by) && ({1'b0, py} < yEnd);
  endfunction

  assign terminal = (state_q == ST_CLEARED) || (state_q == ST_INVADED);

  // Live-alien statistics: population count plus the bounding box of the
  // survivors, which drives the edge tests and the invasion line test.
  always_comb begin
    aliveCnt = '0;
    colLive  = '0;
    rowLive  = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      for (int c = 0; c < NUM_COLUMNS; c++) begin
        if (alive_q[r*NUM_COLUMNS + c]) begin
          aliveCnt   = aliveCnt + 16'd1;
          colLive[c] = 1'b1;
          rowLive[r] = 1'b1;
        end
      end
    end
    lcol = '0;
    for (int c = NUM_COLUMNS - 1; c >= 0; c--) begin
      if (colLive[c]) lcol = COL_W'(c);
    end
    rcol = '0;
    for (int c = 0; c < NUM_COLUMNS; c++) begin
      if (colLive[c]) rcol = COL_W'(c);
    end
    lrow = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (rowLive[r]) lrow = ROW_W'(r);
    end
  end

  assign rightEdge = fx_q + 16'(int'(rcol) * SPACING_X) + 16'(ALIEN_W);
  assign leftEdge  = fx_q + 16'(int'(lcol) * SPACING_X);

  // March period shrinks with fewer aliens and higher level, floored at
  // MIN_PERIOD; done in 32 bits so the subtraction cannot underflow.
  always_comb begin
    periodBase = 32'(MIN_PERIOD) + 32'(aliveCnt) * 32'(PERIOD_PER_ALIEN);
    if (periodBase >= 32'(MIN_PERIOD) + 32'(level_q)) begin
      period = periodBase - 32'(level_q);
    end else begin
      period = 32'(MIN_PERIOD);
    end
  end

  // Shot and scan lookups against the current (pre-step) formation. Boxes
  // never overlap, so at most one live cell can contain the shot.
  always_comb begin
    hitKill   = 1'b0;
    hitIdx    = '0;
    hitRowSel = '0;
    hitColSel = '0;
    pixelHit  = 1'b0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      for (int c = 0; c < NUM_COLUMNS; c++) begin
        if (alive_q[r*NUM_COLUMNS + c]) begin
          if (!hitKill && inBox(bus.hit_x, bus.hit_y,
                                fx_q + 16'(c * SPACING_X), fy_q + 16'(r * SPACING_Y))) begin
            hitKill   = bus.hit_valid;
            hitIdx    = IDX_W'(r*NUM_COLUMNS + c);
            hitRowSel = ROW_W'(r);
            hitColSel = COL_W'(c);
          end
          if (inBox(scan_x_i, scan_y_i,
                    fx_q + 16'(c * SPACING_X), fy_q + 16'(r * SPACING_Y))) begin
            pixelHit = 1'b1;
          end
        end
      end
    end
  end

  // Next-state logic: restart reloads everything; otherwise, outside the
  // terminal states, a hit and a step may both land in the same cycle. The
  // edge tests use the pre-hit bounding box, and a map emptied by this
  // cycle's kill moves straight to CLEARED.
  always_comb begin
    state_d   = state_q;
    alive_d   = alive_q;
    fx_d      = fx_q;
    fy_d      = fy_q;
    tick_d    = tick_q;
    level_d   = level_q;
    hit_ack_d = 1'b0;
    hit_row_d = hit_row_q;
    hit_col_d = hit_col_q;
    pixel_d   = pixelHit;
    stepFire  = 1'b0;

    if (restart_i) begin
      state_d = ST_MARCH_R;
      alive_d = '1;
      fx_d    = 16'(INIT_X);
      fy_d    = 16'(INIT_Y);
      tick_d  = '0;
      level_d = (level_q == 4'hF) ? 4'hF : level_q + 4'd1;
    end else if (!terminal) begin
      if (hitKill) begin
        alive_d[hitIdx] = 1'b0;
        hit_ack_d       = 1'b1;
        hit_row_d       = hitRowSel;
        hit_col_d       = hitColSel;
      end

      if (frame_tick_i) begin
        if (32'(tick_q) + 32'd1 >= period) begin
          stepFire = 1'b1;
          tick_d   = '0;
        end else begin
          tick_d = tick_q + 16'd1;
        end
      end

      if (stepFire) begin
        case (state_q)
          ST_MARCH_R: begin
            if ({1'b0, rightEdge} + 17'(STEP_X) > 17'(SCREEN_W)) state_d = ST_DESC_R;
            else                                                   fx_d = fx_q + 16'(STEP_X);
          end
          ST_DESC_R: begin
            fy_d    = fy_q + 16'(STEP_Y);
            state_d = ST_MARCH_L;
          end
          ST_MARCH_L: begin
            if (leftEdge < 16'(STEP_X)) state_d = ST_DESC_L;
            else                         fx_d = fx_q - 16'(STEP_X);
          end
          ST_DESC_L: begin
            fy_d    = fy_q + 16'(STEP_Y);
            state_d = ST_MARCH_R;
          end
          default: ;
        endcase
        if ({1'b0, fy_d} + 17'(int'(lrow) * SPACING_Y) + 17'(ALIEN_H) >= 17'(INVADE_Y)) begin
          state_d = ST_INVADED;
        end
      end

      if (alive_d == '0) state_d = ST_CLEARED;
    end
  end

  // State register for the formation, shot ack and pixel pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_MARCH_R;
      alive_q   <= '1;
      fx_q      <= 16'(INIT_X);
      fy_q      <= 16'(INIT_Y);
      tick_q    <= '0;
      level_q   <= '0;
      hit_ack_q <= 1'b0;
      hit_row_q <= '0;
      hit_col_q <= '0;
      pixel_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      alive_q   <= alive_d;
      fx_q      <= fx_d;
      fy_q      <= fy_d;
      tick_q    <= tick_d;
      level_q   <= level_d;
      hit_ack_q <= hit_ack_d;
      hit_row_q <= hit_row_d;
      hit_col_q <= hit_col_d;
      pixel_q   <= pixel_d;
    end
  end

`ifdef ALIEN_FIRE_EN
  logic [COL_W-1:0] fire_ptr_q, fire_ptr_d;
  logic             fire_valid_q, fire_valid_d;
  logic [15:0]      fire_x_q, fire_x_d;
  logic [15:0]      fire_y_q, fire_y_d;
  logic             fireFound;
  logic [COL_W-1:0] fireCol;
  logic [ROW_W-1:0] fireRow;
  logic             nextFound;

  function automatic int wrapCol(input int idx);
    return (idx >= NUM_COLUMNS) ? idx - NUM_COLUMNS : idx;
  endfunction

  // Shooter selection: first live column at or after fire_ptr (wrapping),
  // lowest live alien in it; the pointer then moves to the next live column
  // after the shooter, which is the shooter's own column if it is the last.
  always_comb begin
    fireFound = 1'b0;
    fireCol   = '0;
    for (int k = 0; k < NUM_COLUMNS; k++) begin
      if (!fireFound && colLive[wrapCol(int'(fire_ptr_q) + k)]) begin
        fireFound = 1'b1;
        fireCol   = COL_W'(wrapCol(int'(fire_ptr_q) + k));
      end
    end
    fireRow = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (alive_q[r*NUM_COLUMNS + int'(fireCol)]) fireRow = ROW_W'(r);
    end
    nextFound  = 1'b0;
    fire_ptr_d = fire_ptr_q;
    fire_x_d   = fire_x_q;
    fire_y_d   = fire_y_q;
    fire_valid_d = bus.fire_req && fireFound && !terminal && !restart_i;
    if (fire_valid_d) begin
      fire_x_d = fx_q + 16'(int'(fireCol) * SPACING_X) + 16'(ALIEN_W / 2);
      fire_y_d = fy_q + 16'(int'(fireRow) * SPACING_Y) + 16'(ALIEN_H);
      for (int k = 1; k <= NUM_COLUMNS; k++) begin
        if (!nextFound && colLive[wrapCol(int'(fireCol) + k)]) begin
          nextFound  = 1'b1;
          fire_ptr_d = COL_W'(wrapCol(int'(fireCol) + k));
        end
      end
    end
    if (restart_i) fire_ptr_d = '0;
  end

  // Fire pipeline register; the spawn point holds between shots.
  always_ff @(posedge clk) begin
    if (rst) begin
      fire_ptr_q   <= '0;
      fire_valid_q <= 1'b0;
      fire_x_q     <= '0;
      fire_y_q     <= '0;
    end else begin
      fire_ptr_q   <= fire_ptr_d;
      fire_valid_q <= fire_valid_d;
      fire_x_q     <= fire_x_d;
      fire_y_q     <= fire_y_d;
    end
  end

  assign bus.fire_valid = fire_valid_q;
  assign bus.fire_x     = fire_x_q;
  assign bus.fire_y     = fire_y_q;
`else
  logic unusedFireReq;
  assign unusedFireReq  = bus.fire_req;
  assign bus.fire_valid = 1'b0;
  assign bus.fire_x     = '0;
  assign bus.fire_y     = '0;
`endif

  assign bus.hit_ack     = hit_ack_q;
  assign bus.hit_row     = hit_row_q;
  assign bus.hit_col     = hit_col_q;
  assign alive_matrix_o  = alive_q;
  assign alive_count_o   = aliveCnt;
  assign formation_x_o   = fx_q;
  assign formation_y_o   = fy_q;
  assign level_o         = level_q;
  assign state_o         = state_q;
  assign cleared_o       = (state_q == ST_CLEARED);
  assign invaded_o       = (state_q == ST_INVADED);
  assign alien_pixel_o   = pixel_q;

endmodule

// File: tb/tb_alien_swarm_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alien_swarm_ctrl
// Directed bench for alien_swarm_ctrl with default parameters (4x8 swarm,
// 64x32 pitch, 32x16 sprite, origin (100,50)). Expected values are worked
// out by hand from the formation geometry and march rules.
// ---------------------------------------------------------------------------
module tb_alien_swarm_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_tick_i;
  logic        restart_i;
  logic [15:0] scan_x_i;
  logic [15:0] scan_y_i;
  logic [31:0] alive_matrix_o;
  logic [15:0] alive_count_o;
  logic [15:0] formation_x_o;
  logic [15:0] formation_y_o;
  logic [3:0]  level_o;
  logic [2:0]  state_o;
  logic        cleared_o;
  logic        invaded_o;
  logic        alien_pixel_o;

  int checkCount = 0;
  int failCount  = 0;

  alien_swarm_ctrl_if #(.NUM_ROWS(4), .NUM_COLUMNS(8)) bus ();

  alien_swarm_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .frame_tick_i   (frame_tick_i),
    .restart_i      (restart_i),
    .scan_x_i       (scan_x_i),
    .scan_y_i       (scan_y_i),
    .bus            (bus),
    .alive_matrix_o (alive_matrix_o),
    .alive_count_o  (alive_count_o),
    .formation_x_o  (formation_x_o),
    .formation_y_o  (formation_y_o),
    .level_o        (level_o),
    .state_o        (state_o),
    .cleared_o      (cleared_o),
    .invaded_o      (invaded_o),
    .alien_pixel_o  (alien_pixel_o)
  );

  // 10 ns clock; inputs change and outputs are sampled on the falling edge.
  always #5 clk = ~clk;

  // Single comparison point: counts every check, reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // Synchronous reset held for two cycles, released on a falling edge.
  task automatic applyStimulus();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One-cycle shot; on return the registered hit result is visible.
  task automatic applyHit(input logic [15:0] x, input logic [15:0] y);
    bus.hit_valid = 1'b1;
    bus.hit_x     = x;
    bus.hit_y     = y;
    @(negedge clk);
    bus.hit_valid = 1'b0;
  endtask

  // n consecutive frame_tick cycles.
  task automatic tickFrames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick_i = 1'b1;
      @(negedge clk);
    end
    frame_tick_i = 1'b0;
  endtask

  task automatic setScan(input logic [15:0] x, input logic [15:0] y);
    scan_x_i = x;
    scan_y_i = y;
    @(negedge clk);
  endtask

  initial begin
    int acks;
    int guard;

    rst           = 1'b1;
    frame_tick_i  = 1'b0;
    restart_i     = 1'b0;
    scan_x_i      = '0;
    scan_y_i      = '0;
    bus.hit_valid = 1'b0;
    bus.hit_x     = '0;
    bus.hit_y     = '0;
    bus.fire_req  = 1'b0;
    @(negedge clk);

    // ---------------- reset state ----------------
    applyStimulus();
    checkOutput("rst_alive", alive_matrix_o, 32'hFFFF_FFFF);
    checkOutput("rst_count", 32'(alive_count_o), 32);
    checkOutput("rst_fx", 32'(formation_x_o), 100);
    checkOutput("rst_fy", 32'(formation_y_o), 50);
    checkOutput("rst_state", 32'(state_o), 0);
    checkOutput("rst_level", 32'(level_o), 0);
    checkOutput("rst_ack", 32'(bus.hit_ack), 0);
    checkOutput("rst_cleared", 32'(cleared_o), 0);
    checkOutput("rst_invaded", 32'(invaded_o), 0);
    checkOutput("rst_fire", 32'(bus.fire_valid), 0);

    // ---------------- hits ----------------
    applyHit(16'd100, 16'd50);
    checkOutput("hit00_ack", 32'(bus.hit_ack), 1);
    checkOutput("hit00_row", 32'(bus.hit_row), 0);
    checkOutput("hit00_col", 32'(bus.hit_col), 0);
    checkOutput("hit00_count", 32'(alive_count_o), 31);
    checkOutput("hit00_map", 32'(alive_matrix_o[0]), 0);
    @(negedge clk);
    checkOutput("ack_pulse", 32'(bus.hit_ack), 0);
    applyHit(16'd100, 16'd50);
    checkOutput("dead_ack", 32'(bus.hit_ack), 0);
    applyHit(16'd140, 16'd50);
    checkOutput("gap_ack", 32'(bus.hit_ack), 0);
    checkOutput("gap_count", 32'(alive_count_o), 31);
    applyHit(16'd230, 16'd95);
    checkOutput("hit12_ack", 32'(bus.hit_ack), 1);
    checkOutput("hit12_row", 32'(bus.hit_row), 1);
    checkOutput("hit12_col", 32'(bus.hit_col), 2);
    applyHit(16'd260, 16'd50);
    checkOutput("xedge_miss", 32'(bus.hit_ack), 0);
    checkOutput("hold_row", 32'(bus.hit_row), 1);
    checkOutput("hold_col", 32'(bus.hit_col), 2);
    applyHit(16'd259, 16'd65);
    checkOutput("corner_ack", 32'(bus.hit_ack), 1);
    checkOutput("corner_row", 32'(bus.hit_row), 0);
    checkOutput("corner_col", 32'(bus.hit_col), 2);
    checkOutput("hits_count", 32'(alive_count_o), 29);

    // ---------------- pixel render ----------------
    setScan(16'd100, 16'd50);
    checkOutput("pix_dead", 32'(alien_pixel_o), 0);
    setScan(16'd164, 16'd50);
    checkOutput("pix_live", 32'(alien_pixel_o), 1);
    setScan(16'd196, 16'd50);
    checkOutput("pix_xgap", 32'(alien_pixel_o), 0);
    setScan(16'd195, 16'd65);
    checkOutput("pix_corner", 32'(alien_pixel_o), 1);
    setScan(16'd195, 16'd66);
    checkOutput("pix_ygap", 32'(alien_pixel_o), 0);

    // ---------------- alien fire ----------------
`ifdef ALIEN_FIRE_EN
    applyStimulus();
    for (int r = 0; r < 4; r++) applyHit(16'd100, 16'(50 + 32*r));
    bus.fire_req = 1'b1;
    @(negedge clk);
    bus.fire_req = 1'b0;
    checkOutput("fire1_valid", 32'(bus.fire_valid), 1);
    checkOutput("fire1_x", 32'(bus.fire_x), 180);
    checkOutput("fire1_y", 32'(bus.fire_y), 162);
    bus.fire_req = 1'b1;
    @(negedge clk);
    bus.fire_req = 1'b0;
    checkOutput("fire2_x", 32'(bus.fire_x), 244);
    checkOutput("fire2_y", 32'(bus.fire_y), 162);
    @(negedge clk);
    checkOutput("fire_pulse", 32'(bus.fire_valid), 0);
`else
    bus.fire_req = 1'b1;
    @(negedge clk);
    bus.fire_req = 1'b0;
    checkOutput("fire_off_valid", 32'(bus.fire_valid), 0);
    checkOutput("fire_off_x", 32'(bus.fire_x), 0);
`endif

    // ---------------- march timing, right edge, descend ----------------
    applyStimulus();
    tickFrames(65);
    checkOutput("march_65", 32'(formation_x_o), 100);
    tickFrames(1);
    checkOutput("march_66", 32'(formation_x_o), 104);
    tickFrames(14 * 66);
    checkOutput("march_r_end", 32'(formation_x_o), 160);
    checkOutput("march_r_state", 32'(state_o), 0);
    tickFrames(66);
    checkOutput("turn_state", 32'(state_o), 1);
    checkOutput("turn_fx", 32'(formation_x_o), 160);
    tickFrames(66);
    checkOutput("desc_fy", 32'(formation_y_o), 66);
    checkOutput("desc_state", 32'(state_o), 2);
    tickFrames(66);
    checkOutput("march_l_fx", 32'(formation_x_o), 156);

    // ---------------- edge shrink: column 7 destroyed ----------------
    applyStimulus();
    for (int r = 0; r < 4; r++) applyHit(16'd548, 16'(50 + 32*r));
    checkOutput("col7_count", 32'(alive_count_o), 28);
    tickFrames(31 * 58);
    checkOutput("shrink_fx", 32'(formation_x_o), 224);
    checkOutput("shrink_state", 32'(state_o), 0);
    tickFrames(58);
    checkOutput("shrink_turn", 32'(state_o), 1);

    // ---------------- clear and restart ----------------
    applyStimulus();
    acks = 0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 8; c++) begin
        applyHit(16'(100 + 64*c), 16'(50 + 32*r));
        if (bus.hit_ack) acks++;
      end
    end
    checkOutput("clear_acks", 32'(acks), 32);
    checkOutput("clear_flag", 32'(cleared_o), 1);
    checkOutput("clear_state", 32'(state_o), 4);
    checkOutput("clear_count", 32'(alive_count_o), 0);
    tickFrames(200);
    checkOutput("clear_frozen", 32'(formation_x_o), 100);
    restart_i = 1'b1;
    @(negedge clk);
    restart_i = 1'b0;
    checkOutput("restart_level", 32'(level_o), 1);
    checkOutput("restart_map", alive_matrix_o, 32'hFFFF_FFFF);
    checkOutput("restart_fx", 32'(formation_x_o), 100);
    checkOutput("restart_state", 32'(state_o), 0);
    checkOutput("restart_clear", 32'(cleared_o), 0);
    tickFrames(64);
    checkOutput("lvl1_64", 32'(formation_x_o), 100);
    tickFrames(1);
    checkOutput("lvl1_65", 32'(formation_x_o), 104);

    // ---------------- left edge and invasion (only row 3 alive) ----------------
    applyStimulus();
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 8; c++) applyHit(16'(100 + 64*c), 16'(50 + 32*r));
    end
    checkOutput("row3_count", 32'(alive_count_o), 8);
    guard = 0;
    while (state_o != 3'd3 && guard < 5000) begin
      tickFrames(1);
      guard++;
    end
    checkOutput("left_reached", 32'(state_o), 3);
    checkOutput("left_fx", 32'(formation_x_o), 0);
    checkOutput("left_fy", 32'(formation_y_o), 66);
    guard = 0;
    while (!invaded_o && guard < 30000) begin
      tickFrames(1);
      guard++;
    end
    checkOutput("invaded_flag", 32'(invaded_o), 1);
    checkOutput("invaded_state", 32'(state_o), 5);
    checkOutput("invaded_fy", 32'(formation_y_o), 338);
    tickFrames(100);
    checkOutput("inv_frozen_fx", 32'(formation_x_o), 0);
    checkOutput("inv_frozen_fy", 32'(formation_y_o), 338);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
